// File: rtl/memory_access.sv
// Memory stage: one req/ack data-memory transaction per load/store, with sized store lanes and load extension.
// Optional `MEM_MISALIGN_CHECK_EN turns misaligned H/W accesses into bus-free DONE results flagged by misalign_o.
module memory_access #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst,
   input  logic            execute_vaild_i,
   input  logic [XLEN-1:0] ED_valE_i,
   input  logic [XLEN-1:0] ED_valB_i,
   input  logic            ED_mem_read_i,
   input  logic            ED_mem_write_i,
   input  logic [2:0]      ED_funct3_i,
   input  logic            write_back_allow_in_i,
   output logic            memory_ready_o,
   output logic [XLEN-1:0] M_valM_o,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [XLEN-1:0] dmem_addr_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   output logic [3:0]      dmem_wstrb_o,
   input  logic            dmem_ack_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   output logic            misalign_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_reg, state_next;
   logic            req_reg, we_reg, misalign_reg;
   logic [XLEN-1:0] addr_reg, wdata_reg, data_reg;
   logic [3:0]      wstrb_reg;
   logic [1:0]      off_reg;
   logic [2:0]      funct3_reg;

   logic            mem_op, misaligned;
   logic [1:0]      off;
   logic [3:0]      st_strb;
   logic [XLEN-1:0] st_wdata, ld_lane, ld_ext;

   assign mem_op = execute_vaild_i & (ED_mem_read_i | ED_mem_write_i);
   assign off    = ED_valE_i[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
   assign misaligned = ((ED_funct3_i[1:0] == 2'b01) && off[0]) ||
                       (ED_funct3_i[1] && (off != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   // Store lanes: replicate the datum across the word, strobes pick the bytes that land.
   always_comb begin
      st_strb  = 4'b1111;
      st_wdata = ED_valB_i;
      case (ED_funct3_i[1:0])
         2'b00: begin
            st_strb  = 4'b0001 << off;
            st_wdata = {(XLEN/8){ED_valB_i[7:0]}};
         end
         2'b01: begin
            st_strb  = 4'b0011 << off;
            st_wdata = {(XLEN/16){ED_valB_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Load extraction uses the offset/size captured when the request was issued.
   always_comb begin
      ld_lane = dmem_rdata_i >> {off_reg, 3'b000};
      ld_ext  = ld_lane;
      case (funct3_reg[1:0])
         2'b00:   ld_ext = {{(XLEN-8){ld_lane[7] & ~funct3_reg[2]}}, ld_lane[7:0]};
         2'b01:   ld_ext = {{(XLEN-16){ld_lane[15] & ~funct3_reg[2]}}, ld_lane[15:0]};
         default: ld_ext = dmem_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next     = state_reg;
      memory_ready_o = 1'b0;
      M_valM_o       = '0;
      case (state_reg)
         IDLE: begin
            memory_ready_o = ~mem_op;
            if (mem_op) state_next = misaligned ? DONE : BUSY;
         end
         BUSY: begin
            if (dmem_ack_i) state_next = execute_vaild_i ? DONE : IDLE;
         end
         DONE: begin
            memory_ready_o = 1'b1;
            M_valM_o       = data_reg;
            if (write_back_allow_in_i || !execute_vaild_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) begin
         req_reg      <= 1'b0;
         we_reg       <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         wstrb_reg    <= '0;
         data_reg     <= '0;
         misalign_reg <= 1'b0;
         off_reg      <= '0;
         funct3_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (mem_op) begin
                  if (misaligned) begin
                     misalign_reg <= 1'b1;
                     data_reg     <= '0;
                  end else begin
                     req_reg    <= 1'b1;
                     we_reg     <= ED_mem_write_i;
                     addr_reg   <= {ED_valE_i[XLEN-1:2], 2'b00};
                     wdata_reg  <= st_wdata;
                     wstrb_reg  <= st_strb;
                     off_reg    <= off;
                     funct3_reg <= ED_funct3_i;
                  end
               end
            end
            BUSY: begin
               // A flush here never cuts the bus transaction short.
               if (dmem_ack_i) begin
                  req_reg  <= 1'b0;
                  data_reg <= we_reg ? '0 : ld_ext;
               end
            end
            DONE: begin
               if (write_back_allow_in_i || !execute_vaild_i) misalign_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign dmem_req_o   = req_reg;
   assign dmem_we_o    = we_reg;
   assign dmem_addr_o  = addr_reg;
   assign dmem_wdata_o = wdata_reg;
   assign dmem_wstrb_o = wstrb_reg;
   assign misalign_o   = misalign_reg;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: reset, pass-through, sized loads/stores, stalls, flush and reset mid-transaction.
module tb_memory_access;

   logic        clk_i = 1'b0;
   logic        rst;
   logic        execute_vaild_i;
   logic [31:0] ED_valE_i, ED_valB_i;
   logic        ED_mem_read_i, ED_mem_write_i;
   logic [2:0]  ED_funct3_i;
   logic        write_back_allow_in_i;
   logic        memory_ready_o;
   logic [31:0] M_valM_o;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_wstrb_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;
   logic        misalign_o;

   int n_checks = 0;
   int n_fail   = 0;

   memory_access #(.XLEN(32)) dut (
      .clk_i(clk_i), .rst(rst), .execute_vaild_i(execute_vaild_i),
      .ED_valE_i(ED_valE_i), .ED_valB_i(ED_valB_i),
      .ED_mem_read_i(ED_mem_read_i), .ED_mem_write_i(ED_mem_write_i),
      .ED_funct3_i(ED_funct3_i), .write_back_allow_in_i(write_back_allow_in_i),
      .memory_ready_o(memory_ready_o), .M_valM_o(M_valM_o),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
      .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .misalign_o(misalign_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic bubble();
      execute_vaild_i = 1'b0;
      ED_mem_read_i   = 1'b0;
      ED_mem_write_i  = 1'b0;
   endtask

   task automatic present(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rs2);
      execute_vaild_i = 1'b1;
      ED_mem_read_i   = ~wr;
      ED_mem_write_i  = wr;
      ED_valE_i       = addr;
      ED_valB_i       = rs2;
      ED_funct3_i     = f3;
   endtask

   // One full transaction with ack in the first BUSY cycle, then consumed by write-back.
   task automatic run_op(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] rs2, input logic [31:0] rdata,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_val);
      write_back_allow_in_i = 1'b0;
      present(wr, addr, f3, rs2);
      #1;
      check({tag, " ready_idle"}, {31'd0, memory_ready_o}, 32'd0);
      step();
      check({tag, " req"}, {31'd0, dmem_req_o}, 32'd1);
      check({tag, " we"}, {31'd0, dmem_we_o}, {31'd0, wr});
      check({tag, " addr"}, dmem_addr_o, {addr[31:2], 2'b00});
      if (wr) begin
         check({tag, " wstrb"}, {28'd0, dmem_wstrb_o}, {28'd0, exp_strb});
         check({tag, " wdata"}, dmem_wdata_o, exp_wdata);
      end
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = rdata;
      step();
      dmem_ack_i = 1'b0;
      check({tag, " ready_done"}, {31'd0, memory_ready_o}, 32'd1);
      check({tag, " valM"}, M_valM_o, exp_val);
      check({tag, " req_off"}, {31'd0, dmem_req_o}, 32'd0);
      write_back_allow_in_i = 1'b1;
      step();
      write_back_allow_in_i = 1'b0;
      bubble();
      #1;
      check({tag, " ready_after"}, {31'd0, memory_ready_o}, 32'd1);
      $display("txn %s wr=%0d addr=%h f3=%b valM=%h", tag, wr, addr, f3, M_valM_o);
   endtask

   initial begin
      rst = 1'b1;
      bubble();
      ED_valE_i = '0; ED_valB_i = '0; ED_funct3_i = '0;
      write_back_allow_in_i = 1'b0;
      dmem_ack_i = 1'b0; dmem_rdata_i = '0;
      #1 rst = 1'b0;
      #1;
      check("rst ready", {31'd0, memory_ready_o}, 32'd1);
      check("rst valM", M_valM_o, 32'd0);
      check("rst req", {31'd0, dmem_req_o}, 32'd0);
      check("rst we", {31'd0, dmem_we_o}, 32'd0);
      check("rst addr", dmem_addr_o, 32'd0);
      check("rst wdata", dmem_wdata_o, 32'd0);
      check("rst wstrb", {28'd0, dmem_wstrb_o}, 32'd0);
      check("rst misalign", {31'd0, misalign_o}, 32'd0);
      step();
      rst = 1'b1;
      step();
      $display("txn reset done");

      // ALU op passes straight through
      execute_vaild_i = 1'b1;
      write_back_allow_in_i = 1'b1;
      ED_valE_i = 32'h0000_1234;
      #1;
      check("alu ready", {31'd0, memory_ready_o}, 32'd1);
      check("alu valM", M_valM_o, 32'd0);
      step();
      check("alu noreq", {31'd0, dmem_req_o}, 32'd0);
      check("alu ready2", {31'd0, memory_ready_o}, 32'd1);
      $display("txn alu pass-through ready=%0d", memory_ready_o);

      // LB 0x1003, ack three cycles after req, then 4-cycle stall in DONE
      write_back_allow_in_i = 1'b0;
      present(1'b0, 32'h0000_1003, 3'b000, 32'd0);
      step();
      for (int i = 0; i < 2; i++) begin
         check("lb req_hold", {31'd0, dmem_req_o}, 32'd1);
         check("lb busy_ready", {31'd0, memory_ready_o}, 32'd0);
         step();
      end
      check("lb addr", dmem_addr_o, 32'h0000_1000);
      dmem_ack_i = 1'b1;
      dmem_rdata_i = 32'h80FF_0000;
      #1;
      check("lb ack_ready", {31'd0, memory_ready_o}, 32'd0);
      step();
      dmem_ack_i = 1'b0;
      dmem_rdata_i = 32'hAAAA_AAAA;
      check("lb ready", {31'd0, memory_ready_o}, 32'd1);
      check("lb valM", M_valM_o, 32'hFFFF_FF80);
      for (int i = 0; i < 4; i++) begin
         step();
         check("stall valM", M_valM_o, 32'hFFFF_FF80);
         check("stall noreq", {31'd0, dmem_req_o}, 32'd0);
         check("stall ready", {31'd0, memory_ready_o}, 32'd1);
      end
      write_back_allow_in_i = 1'b1;
      step();
      write_back_allow_in_i = 1'b0;
      bubble();
      #1;
      check("lb consumed valM", M_valM_o, 32'd0);
      $display("txn LB 0x1003 with stall complete");

      run_op("LBU", 1'b0, 32'h0000_1003, 3'b100, 32'd0, 32'h80FF_0000, 4'd0, 32'd0, 32'h0000_0080);
      run_op("LH_hi", 1'b0, 32'h0000_1002, 3'b001, 32'd0, 32'h80FF_0000, 4'd0, 32'd0, 32'hFFFF_80FF);
      run_op("LHU", 1'b0, 32'h0000_1000, 3'b101, 32'd0, 32'h1234_8765, 4'd0, 32'd0, 32'h0000_8765);
      run_op("LH_lo", 1'b0, 32'h0000_1000, 3'b001, 32'd0, 32'h1234_8765, 4'd0, 32'd0, 32'hFFFF_8765);
      run_op("LB_b1", 1'b0, 32'h0000_1001, 3'b000, 32'd0, 32'h1234_5678, 4'd0, 32'd0, 32'h0000_0056);
      run_op("LW", 1'b0, 32'h0000_1004, 3'b010, 32'd0, 32'hDEAD_BEEF, 4'd0, 32'd0, 32'hDEAD_BEEF);
      run_op("SH", 1'b1, 32'h0000_2002, 3'b001, 32'h0000_BEEF, 32'h5555_5555, 4'b1100, 32'hBEEF_BEEF, 32'd0);
      run_op("SB", 1'b1, 32'h0000_2001, 3'b000, 32'h1234_56A5, 32'h5555_5555, 4'b0010, 32'hA5A5_A5A5, 32'd0);
      run_op("SW", 1'b1, 32'h0000_2008, 3'b010, 32'hCAFE_F00D, 32'h5555_5555, 4'b1111, 32'hCAFE_F00D, 32'd0);
`ifndef MEM_MISALIGN_CHECK_EN
      run_op("SW_mis", 1'b1, 32'h0000_2001, 3'b010, 32'h0BAD_CAFE, 32'd0, 4'b1111, 32'h0BAD_CAFE, 32'd0);
      run_op("SH_off3", 1'b1, 32'h0000_2003, 3'b001, 32'h0000_1357, 32'd0, 4'b1000, 32'h1357_1357, 32'd0);
      check("nocheck misalign", {31'd0, misalign_o}, 32'd0);
`else
      present(1'b0, 32'h0000_3001, 3'b010, 32'd0);
      #1;
      check("mis ready_idle", {31'd0, memory_ready_o}, 32'd0);
      step();
      check("mis noreq", {31'd0, dmem_req_o}, 32'd0);
      check("mis flag", {31'd0, misalign_o}, 32'd1);
      check("mis ready", {31'd0, memory_ready_o}, 32'd1);
      check("mis valM", M_valM_o, 32'd0);
      write_back_allow_in_i = 1'b1;
      step();
      write_back_allow_in_i = 1'b0;
      bubble();
      #1;
      check("mis cleared", {31'd0, misalign_o}, 32'd0);
      $display("txn LW 0x3001 misaligned");
`endif

      // Flush while BUSY: request held to ack, result dropped
      present(1'b0, 32'h0000_1000, 3'b010, 32'd0);
      step();
      bubble();
      for (int i = 0; i < 2; i++) begin
         step();
         check("flush req_hold", {31'd0, dmem_req_o}, 32'd1);
      end
      dmem_ack_i = 1'b1;
      dmem_rdata_i = 32'h1111_1111;
      step();
      dmem_ack_i = 1'b0;
      check("flush req_off", {31'd0, dmem_req_o}, 32'd0);
      check("flush valM", M_valM_o, 32'd0);
      check("flush ready", {31'd0, memory_ready_o}, 32'd1);
      step();
      check("flush noreissue", {31'd0, dmem_req_o}, 32'd0);
      check("flush valM2", M_valM_o, 32'd0);
      $display("txn LW flushed in BUSY");

      // Reset asserted mid-BUSY
      present(1'b1, 32'h0000_2004, 3'b010, 32'h7777_7777);
      step();
      check("rbusy req", {31'd0, dmem_req_o}, 32'd1);
      bubble();
      rst = 1'b0;
      #1;
      check("rbusy req_off", {31'd0, dmem_req_o}, 32'd0);
      check("rbusy ready", {31'd0, memory_ready_o}, 32'd1);
      check("rbusy valM", M_valM_o, 32'd0);
      check("rbusy wstrb", {28'd0, dmem_wstrb_o}, 32'd0);
      step();
      rst = 1'b1;
      step();
      check("rbusy idle_noreq", {31'd0, dmem_req_o}, 32'd0);
      $display("txn reset mid-BUSY");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
